// File: rtl/pid_pkg.sv
// Shared definitions for the PID sample sequencer: register map, FSM states
// and the minimum sample period.
package pid_pkg;

    localparam int unsigned PID_ADR_PV = 32'h10;
    localparam int unsigned PID_ADR_UN = 32'h20;
    localparam int unsigned PID_ADR_OF = 32'h28;
    localparam int unsigned MIN_PERIOD = 32;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_REQ_PV,
        ST_WR_PV,
        ST_GUARD,
        ST_WAIT_CALC,
        ST_RD_UN,
        ST_GAP,
        ST_RD_OF,
        ST_DONE
    } seq_state_e;

    // Periods shorter than the controller can sustain are stretched to the minimum.
    function automatic logic [15:0] eff_period(input logic [15:0] period);
        return (period < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : period;
    endfunction

endpackage

// File: rtl/wb_master_single.sv
// Single classic Wishbone read/write: launched by go_i, finished by ack
// (done_o, combinational with ack) or abandoned after 2^TO_W-1 strobe cycles.
module wb_master_single #(
    parameter int ADR_W = 16,
    parameter int DW    = 32,
    parameter int TO_W  = 8
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             go_i,
    input  logic             we_i,
    input  logic [ADR_W-1:0] adr_i,
    input  logic [DW-1:0]    wdata_i,
    output logic             done_o,
    output logic [DW-1:0]    rdata_o,
    output logic             timeout_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [DW-1:0]    wb_data_o,
    input  logic             wb_ack_i,
    input  logic [DW-1:0]    wb_data_i
);
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    logic             cyc_q;
    logic             we_q;
    logic [ADR_W-1:0] adr_q;
    logic [DW-1:0]    dat_q;
    logic [TO_W-1:0]  cnt_q;

    assign done_o    = cyc_q && wb_ack_i;
    assign timeout_o = cyc_q && !wb_ack_i && (cnt_q == TO_LAST);
    assign rdata_o   = wb_data_i;

    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = cyc_q && we_q;
    assign wb_adr_o  = adr_q;
    assign wb_data_o = dat_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order of statements or blocks.
    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            cnt_q <= '0;
        end else if (!cyc_q) begin
            cnt_q <= '0;
            if (go_i) begin
                cyc_q <= 1'b1;
                we_q  <= we_i;
                adr_q <= adr_i;
                dat_q <= wdata_i;
            end
        end else if (wb_ack_i || timeout_o) begin
            cyc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pid_sample_sequencer.sv
// Fixed-rate Wishbone master for the PID slave: sample the sensor, write pv,
// wait for the update, read back un/of and strobe them to the actuator.
module pid_sample_sequencer
    import pid_pkg::*;
#(
    parameter int ADR_W = 16,
    parameter int DW    = 32,
    parameter int TO_W  = 8
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [15:0]      i_period,
    output logic             o_pv_req,
    input  logic             i_pv_valid,
    input  logic [15:0]      i_pv,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    output logic             o_wb_we,
    output logic [ADR_W-1:0] o_wb_adr,
    output logic [DW-1:0]    o_wb_data,
    input  logic             i_wb_ack,
    input  logic [DW-1:0]    i_wb_data,
    input  logic             i_pid_valid,
    output logic [31:0]      o_un,
    output logic [4:0]       o_of,
    output logic             o_un_valid,
    output logic             o_overrun,
    output logic             o_err,
    output logic             o_busy
);
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    seq_state_e      state_q, state_d;
    logic [15:0]     per_cnt_q;
    logic [TO_W-1:0] st_cnt_q;
    logic [15:0]     pv_q;
    logic [31:0]     un_sh_q, un_q;
    logic [4:0]      of_sh_q, of_q;
    logic            pv_req_q, un_valid_q, overrun_q, err_q, en_q;

    logic             tick, en_rise, wait_to;
    logic             m_go, m_we, m_done, m_to;
    logic [ADR_W-1:0] m_adr;
    logic [DW-1:0]    m_wdata, m_rdata;

    assign tick    = i_en && (state_q != ST_IDLE)
                   && (per_cnt_q >= eff_period(i_period) - 16'd1);
    assign en_rise = i_en && !en_q;

    // A bus state launches its transaction on its first cycle, while the bus is still idle.
    assign m_go    = (state_q inside {ST_WR_PV, ST_RD_UN, ST_RD_OF}) && !o_wb_cyc;
    assign m_we    = (state_q == ST_WR_PV);
    assign m_adr   = (state_q == ST_RD_UN) ? ADR_W'(PID_ADR_UN) :
                     (state_q == ST_RD_OF) ? ADR_W'(PID_ADR_OF) : ADR_W'(PID_ADR_PV);
    assign m_wdata = {{(DW-16){pv_q[15]}}, pv_q};

    wb_master_single #(.ADR_W(ADR_W), .DW(DW), .TO_W(TO_W)) u_wb (
        .i_clk     (i_clk),
        .rst       (rst),
        .go_i      (m_go),
        .we_i      (m_we),
        .adr_i     (m_adr),
        .wdata_i   (m_wdata),
        .done_o    (m_done),
        .rdata_o   (m_rdata),
        .timeout_o (m_to),
        .wb_cyc_o  (o_wb_cyc),
        .wb_stb_o  (o_wb_stb),
        .wb_we_o   (o_wb_we),
        .wb_adr_o  (o_wb_adr),
        .wb_data_o (o_wb_data),
        .wb_ack_i  (i_wb_ack),
        .wb_data_i (i_wb_data)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        wait_to = 1'b0;
        case (state_q)
            ST_IDLE:      if (i_en) state_d = ST_WAIT_TICK;
            ST_WAIT_TICK: if (!i_en) state_d = ST_IDLE;
                          else if (tick) state_d = ST_REQ_PV;
            ST_REQ_PV: begin
                if (i_pv_valid) state_d = ST_WR_PV;
                else if (st_cnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    wait_to = 1'b1;
                end
            end
            ST_WR_PV:     if (m_done) state_d = ST_GUARD;
                          else if (m_to) state_d = ST_IDLE;
            // The controller's valid is stale right after the write; skip it for two cycles.
            ST_GUARD:     if (st_cnt_q == TO_W'(1)) state_d = ST_WAIT_CALC;
            ST_WAIT_CALC: begin
                if (i_pid_valid) state_d = ST_RD_UN;
                else if (st_cnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    wait_to = 1'b1;
                end
            end
            ST_RD_UN:     if (m_done) state_d = ST_GAP;
                          else if (m_to) state_d = ST_IDLE;
            ST_GAP:       state_d = ST_RD_OF;
            ST_RD_OF:     if (m_done) state_d = ST_DONE;
                          else if (m_to) state_d = ST_IDLE;
            ST_DONE:      state_d = i_en ? ST_WAIT_TICK : ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            per_cnt_q  <= '0;
            st_cnt_q   <= '0;
            pv_q       <= '0;
            un_sh_q    <= '0;
            of_sh_q    <= '0;
            un_q       <= '0;
            of_q       <= '0;
            pv_req_q   <= 1'b0;
            un_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            err_q      <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= i_en;
            st_cnt_q   <= (state_d != state_q) ? '0 : st_cnt_q + 1'b1;
            per_cnt_q  <= (state_q == ST_IDLE || tick) ? '0 : per_cnt_q + 16'd1;
            pv_req_q   <= (state_q == ST_WAIT_TICK) && (state_d == ST_REQ_PV);
            un_valid_q <= (state_q == ST_DONE);
            if (state_q == ST_REQ_PV && i_pv_valid) pv_q <= i_pv;
            if (state_q == ST_RD_UN && m_done) un_sh_q <= m_rdata[31:0];
            if (state_q == ST_RD_OF && m_done) of_sh_q <= m_rdata[4:0];
            if (state_q == ST_DONE) begin
                un_q <= un_sh_q;
                of_q <= of_sh_q;
            end
            // Sticky flags: a restart clears them, a new event in the same cycle wins.
            if (en_rise) begin
                overrun_q <= 1'b0;
                err_q     <= 1'b0;
            end
            if (tick && state_q != ST_WAIT_TICK) overrun_q <= 1'b1;
            if (m_to || wait_to) err_q <= 1'b1;
        end
    end

    assign o_pv_req   = pv_req_q;
    assign o_un       = un_q;
    assign o_of       = of_q;
    assign o_un_valid = un_valid_q;
    assign o_overrun  = overrun_q;
    assign o_err      = err_q;
    assign o_busy     = !(state_q inside {ST_IDLE, ST_WAIT_TICK});

endmodule

// File: doc/pid_sample_sequencer.md
# pid_sample_sequencer

Fixed-rate Wishbone master that drives the PID controller's slave port once per sample period. Each period it fetches a process value from the sensor front-end and writes it to the PID `pv` register, which starts an e(n)/sigma/u(n) update. It then waits for the controller's `o_valid`, reads back `un` and the overflow register, and presents them to the actuator with a one-cycle strobe. It sits between sensor, PID slave and actuator, and is the only Wishbone master on the PID port.

## Interface

**Parameters**
- `ADR_W`, 16: Wishbone address width.
- `DW`, 32: Wishbone data width. The PID slave is built in 32-bit mode.
- `TO_W`, 8: width of the ack-timeout counter.

**Ports**
- `i_clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `i_en`, in, 1: run enable. When low, the block finishes the current transaction and then idles.
- `i_period`, in, 16: sample period in cycles. Values below 32 are treated as 32.
- `o_pv_req`, out, 1: one-cycle request to the sensor front-end.
- `i_pv_valid`, in, 1: sensor data valid.
- `i_pv`, in, 16: signed process value.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`, out, 1 each: Wishbone master controls.
- `o_wb_adr`, out, `ADR_W`: Wishbone address.
- `o_wb_data`, out, `DW`: Wishbone write data.
- `i_wb_ack`, in, 1: Wishbone acknowledge.
- `i_wb_data`, in, `DW`: Wishbone read data.
- `i_pid_valid`, in, 1: the PID controller's `o_valid`.
- `o_un`, out, 32: latest u(n).
- `o_of`, out, 5: latest overflow flags.
- `o_un_valid`, out, 1: one-cycle strobe for new `o_un`/`o_of`.
- `o_overrun`, out, 1: sticky; a tick arrived while a sample was still in progress.
- `o_err`, out, 1: sticky; ack timeout or sensor timeout.
- `o_busy`, out, 1: FSM is not in IDLE or WAIT_TICK.

## Operation

**Register addresses (byte):** `pv` 0x10, `un` 0x20, `of` 0x28.

**FSM states:** IDLE, WAIT_TICK, REQ_PV, WR_PV, GUARD, WAIT_CALC, RD_UN, GAP, RD_OF, DONE.

**Transitions**
- IDLE → WAIT_TICK when `i_en` is high. The period counter clears on this transition.
- WAIT_TICK → REQ_PV on tick. The tick fires when the counter reaches `max(i_period,32)-1`; the counter then wraps to 0 and keeps free-running while `i_en` is high.
- REQ_PV: assert `o_pv_req` for one cycle, then wait for `i_pv_valid`. Latch `i_pv` and go to WR_PV.
- WR_PV: `cyc=stb=we=1`, `adr=0x10`, data = `i_pv` sign-extended to `DW`. Hold until `i_wb_ack`. On ack, drop `cyc`/`stb` the next cycle and go to GUARD.
- GUARD: 2 cycles. `i_pid_valid` is ignored here, because the controller lowers it one cycle after the write ack.
- WAIT_CALC: wait for `i_pid_valid`=1, then go to RD_UN.
- RD_UN: read 0x20 and latch `i_wb_data` into the `un` shadow on ack. Then GAP (1 idle bus cycle), then RD_OF.
- RD_OF: read 0x28 and latch `i_wb_data[4:0]`. Then DONE.
- DONE: update `o_un`/`o_of` from the shadows and pulse `o_un_valid`. Go to WAIT_TICK if `i_en` is high, otherwise IDLE.

**Bus rules**
- At least one cycle with `cyc=stb=0` between consecutive transactions.
- Address and data are stable for the whole strobe.

**Timeouts**
- Any bus state without ack for 2^`TO_W`-1 cycles, or REQ_PV/WAIT_CALC lasting that long: drop `cyc`/`stb`, set `o_err`, go to IDLE. `o_un` keeps its previous value.
- `o_err` and `o_overrun` clear only on reset, or on an `i_en` 0→1 edge.

**Overrun:** a tick outside WAIT_TICK is dropped and sets `o_overrun`. The in-flight sample completes normally.

**`i_en` low mid-sample:** the current state sequence runs to DONE, then the block goes to IDLE. A Wishbone cycle is never truncated.

## Timing

- **Reset values:** all outputs 0, FSM in IDLE, counters 0.
- **Write:** `stb` is asserted the cycle after entering WR_PV. It deasserts the cycle after ack.
- **Reads:** the slave acks combinationally, so a read completes in 1 cycle. `stb` deasserts on the following cycle.
- **Minimum tick-to-`o_un_valid` latency:** 1 (REQ) + sensor latency + 2 (WR) + 2 (GUARD) + controller compute + 2 (RD_UN) + 1 (GAP) + 2 (RD_OF) + 1 (DONE).
- **Controller compute:** about 15 cycles. The 32-cycle minimum period covers it only with 0-latency sensor and ack; longer latencies must be covered by a larger `i_period`.
- **Tick and DONE in the same cycle:** counts as an overrun, and the tick is dropped.

## Structure

- **Shared package `pid_pkg`:** register byte addresses (`PID_ADR_PV`, `PID_ADR_UN`, `PID_ADR_OF`), the state enum, and `MIN_PERIOD`=32.
- **Sub-module `wb_master_single`:** one classic single read/write with timeout. Inputs: `go`, `we`, `adr`, `wdata`. Outputs: `done`, `rdata`, `timeout`. The FSM instantiates it once.

## Test plan

1. **Nominal sample:** `i_period`=100, sensor returns 0x0010 after 3 cycles, slave model acks in 1 cycle, `i_pid_valid` drops 1 cycle after the write ack and rises after 15 cycles, un=0x00000123, of=0. → Write to 0x10 with data 0x00000010; `o_un`=0x123; one `o_un_valid` every 100 cycles.
2. **Negative pv:** pv=0x8001. → Write data 0xFFFF8001.
3. **Short period:** `i_period`=5. → Ticks every 32 cycles.
4. **Overrun:** `i_period`=32 with compute stretched to 40 cycles. → `o_overrun`=1; every sample still completes with no truncated bus cycle.
5. **Ack timeout:** the slave never acks the write. → After 255 cycles `cyc`/`stb`=0, `o_err`=1, FSM in IDLE, `o_un` unchanged.
6. **`i_en` and reset mid-sample:** drop `i_en` during WAIT_CALC. → Sample completes, then IDLE. Assert `rst` during RD_UN. → All outputs 0 immediately.
